// File: rtl/noobs_mem_pkg.sv
// Shared definitions for the unified-SRAM arbiter: requester IDs, grant
// bit positions and default bus widths.
package noobs_mem_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 8;

   // Bit positions inside the one-hot grant vector
   localparam int GNT_IF = 0;
   localparam int GNT_D  = 1;
   localparam int GNT_X  = 2;

   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_IF   = 2'd1,
      REQ_D    = 2'd2,
      REQ_X    = 2'd3
   } req_id_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and SRAM-side bus of the memory arbiter. The slave modport is the
// arbiter's view; the master modport is the view of the surrounding system
// (requesters plus SRAM macro).
interface mem_arbiter_if
   import noobs_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;

   logic              d_req;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;

   logic              x_req;
   logic              x_wr;
   logic [ADDR_W-1:0] x_addr;
   logic [DATA_W-1:0] x_wdata;
   logic              x_gnt;
   logic              x_rvalid;

   logic [DATA_W-1:0] rdata;

   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      input  d_req, d_wr, d_addr, d_wdata,
      input  x_req, x_wr, x_addr, x_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, d_gnt, d_rvalid, x_gnt, x_rvalid,
      output rdata, mem_en, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr,
      output d_req, d_wr, d_addr, d_wdata,
      output x_req, x_wr, x_addr, x_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, d_gnt, d_rvalid, x_gnt, x_rvalid,
      input  rdata, mem_en, mem_wr, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational priority picker: loader beats data beats fetch, except that a
// starved fetch jumps ahead of the data port (never ahead of the loader).
module mem_arb_pick
   import noobs_mem_pkg::*;
(
   input  logic       x_req,
   input  logic       d_req,
   input  logic       if_req,
   input  logic       starve_hit,
   output logic [2:0] gnt,
   output req_id_e    winner
);

   // Select a single winner from this cycle's requests
   always_comb begin
      gnt    = 3'b000;
      winner = REQ_NONE;
      if (x_req) begin
         gnt[GNT_X] = 1'b1;
         winner     = REQ_X;
      end else if (if_req && starve_hit) begin
         gnt[GNT_IF] = 1'b1;
         winner      = REQ_IF;
      end else if (d_req) begin
         gnt[GNT_D] = 1'b1;
         winner     = REQ_D;
      end else if (if_req) begin
         gnt[GNT_IF] = 1'b1;
         winner      = REQ_IF;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter for fetch, data and loader/debug requesters.
// Grants are combinational (zero latency); read data returns one cycle later
// tagged by the registered owner of the accepted read.
module mem_arbiter
   import noobs_mem_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int STARVE_LIMIT = 4
) (
   input logic          clk,
   input logic          reset_,
   mem_arbiter_if.slave bus
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]        starve_cnt_reg;
   req_id_e           owner_reg;
   logic              starve_hit;
   logic [2:0]        gnt;
   req_id_e           winner;
   logic              mux_wr;
   logic [ADDR_W-1:0] mux_addr;
   logic [DATA_W-1:0] mux_wdata;
   logic              mux_en;

   // Override only fires while fetch is actually asking
   assign starve_hit = bus.if_req && (starve_cnt_reg == LIMIT);

   mem_arb_pick u_pick (
      .x_req      (bus.x_req),
      .d_req      (bus.d_req),
      .if_req     (bus.if_req),
      .starve_hit (starve_hit),
      .gnt        (gnt),
      .winner     (winner)
   );

   assign mux_en = |gnt;

   // Route the winner's command to the SRAM; idle bus is driven to zero
   always_comb begin
      mux_wr    = 1'b0;
      mux_addr  = '0;
      mux_wdata = '0;
      case (winner)
         REQ_X: begin
            mux_wr    = bus.x_wr;
            mux_addr  = bus.x_addr;
            mux_wdata = bus.x_wdata;
         end
         REQ_D: begin
            mux_wr    = bus.d_wr;
            mux_addr  = bus.d_addr;
            mux_wdata = bus.d_wdata;
         end
         REQ_IF: begin
            mux_addr  = bus.if_addr;
         end
         default: ;
      endcase
   end

   // Count consecutive cycles fetch waited while requesting, saturating
   always_ff @(posedge clk or posedge reset_) begin
      if (reset_) begin
         starve_cnt_reg <= 4'd0;
      end else if (gnt[GNT_IF] || !bus.if_req) begin
         starve_cnt_reg <= 4'd0;
      end else if (starve_cnt_reg != LIMIT) begin
         starve_cnt_reg <= starve_cnt_reg + 4'd1;
      end
   end

   // Remember who owns the read data returning next cycle
   always_ff @(posedge clk or posedge reset_) begin
      if (reset_) begin
         owner_reg <= REQ_NONE;
      end else if (mux_en && !mux_wr) begin
         owner_reg <= winner;
      end else begin
         owner_reg <= REQ_NONE;
      end
   end

   assign bus.x_gnt     = gnt[GNT_X];
   assign bus.d_gnt     = gnt[GNT_D];
   assign bus.if_gnt    = gnt[GNT_IF];

   assign bus.mem_en    = mux_en;
   assign bus.mem_wr    = mux_wr;
   assign bus.mem_addr  = mux_addr;
   assign bus.mem_wdata = mux_wdata;

   assign bus.x_rvalid  = (owner_reg == REQ_X);
   assign bus.d_rvalid  = (owner_reg == REQ_D);
   assign bus.if_rvalid = (owner_reg == REQ_IF);
   assign bus.rdata     = (owner_reg != REQ_NONE) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus checks grants and pushes expected
// read returns into a queue; a negedge monitor pops and compares them.
module tb_mem_arbiter;
   import noobs_mem_pkg::*;

   logic clk = 1'b0;
   logic reset_ = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

   mem_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_LIMIT(4)) dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus)
   );

   // Write-first synchronous SRAM model, one cycle read latency
   logic [7:0] sram [0:4095];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_wr) begin
            sram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata      <= bus.mem_wdata;
         end else begin
            bus.mem_rdata <= sram[bus.mem_addr];
         end
      end
   end

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic drive(input logic xr, input logic xw, input logic [11:0] xa, input logic [7:0] xd,
                        input logic dr, input logic dw, input logic [11:0] da, input logic [7:0] dd,
                        input logic ir, input logic [11:0] ia);
      bus.x_req  = xr; bus.x_wr = xw; bus.x_addr = xa; bus.x_wdata = xd;
      bus.d_req  = dr; bus.d_wr = dw; bus.d_addr = da; bus.d_wdata = dd;
      bus.if_req = ir; bus.if_addr = ia;
   endtask

   task automatic idle();
      drive(0, 0, 12'h0, 8'h0, 0, 0, 12'h0, 8'h0, 0, 12'h0);
   endtask

   // Called at a negedge: check grant vector for the current cycle
   task automatic exp_gnt(input string name, input logic xg, input logic dg, input logic ig);
      chk(name, {29'd0, bus.x_gnt, bus.d_gnt, bus.if_gnt}, {29'd0, xg, dg, ig});
      $display("txn %s: gnt x/d/if=%0b%0b%0b addr=0x%03h wr=%0b", name,
               bus.x_gnt, bus.d_gnt, bus.if_gnt, bus.mem_addr, bus.mem_wr);
   endtask

   task automatic push_rd(input logic [1:0] id, input logic [7:0] data);
      exp_t e;
      e.id = id; e.data = data; e.due = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: one-hot properties each cycle, scoreboard on every read return
   always @(negedge clk) begin
      logic [1:0] act_id;
      exp_t       e;
      chk("gnt_onehot0", {31'd0, $onehot0({bus.x_gnt, bus.d_gnt, bus.if_gnt})}, 32'd1);
      chk("rvalid_onehot0", {31'd0, $onehot0({bus.x_rvalid, bus.d_rvalid, bus.if_rvalid})}, 32'd1);
      act_id = bus.x_rvalid ? 2'd3 : bus.d_rvalid ? 2'd2 : bus.if_rvalid ? 2'd1 : 2'd0;
      if (act_id != 2'd0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rvalid: owner %0d rdata 0x%02h with none expected (cycle %0d)",
                     act_id, bus.rdata, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("rvalid_owner", {30'd0, act_id}, {30'd0, e.id});
            chk("rdata", {24'd0, bus.rdata}, {24'd0, e.data});
            chk("rvalid_cycle", cyc, e.due);
            $display("txn read_return: owner=%0d rdata=0x%02h", act_id, bus.rdata);
         end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
         e = exp_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL missing_rvalid: no return, required owner %0d data 0x%02h (cycle %0d)",
                  e.id, e.data, cyc);
      end
   end

   initial begin
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      // Reset state
      chk("rst_gnt", {29'd0, bus.x_gnt, bus.d_gnt, bus.if_gnt}, 32'd0);
      chk("rst_mem_en_wr", {30'd0, bus.mem_en, bus.mem_wr}, 32'd0);
      chk("rst_mem_addr", {20'd0, bus.mem_addr}, 32'd0);
      chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
      chk("rst_rdata", {24'd0, bus.rdata}, 32'd0);
      @(posedge clk); #1;
      reset_ = 1'b0;

      // Loader preloads SRAM
      drive(1, 1, 12'h010, 8'hA5, 0, 0, 12'h0, 8'h0, 0, 12'h0);
      @(negedge clk); exp_gnt("load_010", 1, 0, 0);
      chk("load_mem_wr", {31'd0, bus.mem_wr}, 32'd1);
      chk("load_mem_wdata", {24'd0, bus.mem_wdata}, 32'hA5);
      tick();
      drive(1, 1, 12'h200, 8'h77, 0, 0, 12'h0, 8'h0, 0, 12'h0);
      @(negedge clk); exp_gnt("load_200", 1, 0, 0);
      tick(); idle(); tick();

      // Single fetch
      drive(0, 0, 12'h0, 8'h0, 0, 0, 12'h0, 8'h0, 1, 12'h010);
      @(negedge clk); exp_gnt("fetch", 0, 0, 1);
      chk("fetch_mem_addr", {20'd0, bus.mem_addr}, 32'h010);
      chk("fetch_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      push_rd(2'd1, 8'hA5);
      tick(); idle(); tick(); tick();

      // Contention: data wins 4 cycles, then starved fetch overrides
      drive(0, 0, 12'h0, 8'h0, 1, 0, 12'h200, 8'h0, 1, 12'h010);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); exp_gnt("contend_d", 0, 1, 0);
         push_rd(2'd2, 8'h77);
         tick();
      end
      @(negedge clk); exp_gnt("starve_override", 0, 0, 1);
      push_rd(2'd1, 8'hA5);
      tick();
      bus.if_req = 1'b0;
      @(negedge clk); exp_gnt("after_override", 0, 1, 0);
      push_rd(2'd2, 8'h77);
      tick(); idle(); tick();

      // Loader beats a starved fetch
      drive(0, 0, 12'h0, 8'h0, 1, 0, 12'h200, 8'h0, 1, 12'h010);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); exp_gnt("contend2_d", 0, 1, 0);
         push_rd(2'd2, 8'h77);
         tick();
      end
      drive(1, 1, 12'hFFF, 8'h3C, 1, 0, 12'h200, 8'h0, 1, 12'h010);
      @(negedge clk); exp_gnt("x_over_starve", 1, 0, 0);
      chk("x_mem_wr", {31'd0, bus.mem_wr}, 32'd1);
      chk("x_mem_addr", {20'd0, bus.mem_addr}, 32'hFFF);
      chk("x_mem_wdata", {24'd0, bus.mem_wdata}, 32'h3C);
      tick();
      bus.x_req = 1'b0;
      @(negedge clk); exp_gnt("override_after_x", 0, 0, 1);
      push_rd(2'd1, 8'hA5);
      tick();
      bus.if_req = 1'b0;
      @(negedge clk); exp_gnt("d_after_x", 0, 1, 0);
      push_rd(2'd2, 8'h77);
      tick(); idle(); tick();

      // Write-then-read back to back, plus readback of the loader write
      drive(0, 0, 12'h0, 8'h0, 1, 1, 12'h123, 8'h5A, 0, 12'h0);
      @(negedge clk); exp_gnt("d_write", 0, 1, 0);
      tick();
      drive(0, 0, 12'h0, 8'h0, 1, 0, 12'h123, 8'h0, 0, 12'h0);
      @(negedge clk); exp_gnt("d_read_123", 0, 1, 0);
      push_rd(2'd2, 8'h5A);
      tick();
      drive(0, 0, 12'h0, 8'h0, 1, 0, 12'hFFF, 8'h0, 0, 12'h0);
      @(negedge clk); exp_gnt("d_read_fff", 0, 1, 0);
      push_rd(2'd2, 8'h3C);
      tick();
      drive(1, 0, 12'h123, 8'h0, 0, 0, 12'h0, 8'h0, 0, 12'h0);
      @(negedge clk); exp_gnt("x_read_123", 1, 0, 0);
      push_rd(2'd3, 8'h5A);
      tick(); idle(); tick(); tick();

      // Reset asserted while a fetch read is in flight
      drive(0, 0, 12'h0, 8'h0, 1, 0, 12'h200, 8'h0, 1, 12'h010);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); exp_gnt("pre_rst_d", 0, 1, 0);
         push_rd(2'd2, 8'h77);
         tick();
      end
      bus.d_req = 1'b0;
      @(negedge clk); exp_gnt("rst_fetch", 0, 0, 1);
      #1;
      reset_ = 1'b1;
      idle();
      @(posedge clk);
      @(negedge clk);
      chk("midrst_gnt", {29'd0, bus.x_gnt, bus.d_gnt, bus.if_gnt}, 32'd0);
      chk("midrst_rvalid", {29'd0, bus.x_rvalid, bus.d_rvalid, bus.if_rvalid}, 32'd0);
      chk("midrst_mem", {30'd0, bus.mem_en, bus.mem_wr}, 32'd0);
      chk("midrst_rdata", {24'd0, bus.rdata}, 32'd0);
      chk("midrst_starve", {28'd0, dut.starve_cnt_reg}, 32'd0);
      @(posedge clk); #1;
      reset_ = 1'b0;
      drive(0, 0, 12'h0, 8'h0, 0, 0, 12'h0, 8'h0, 1, 12'h010);
      @(negedge clk); exp_gnt("post_rst_fetch", 0, 0, 1);
      push_rd(2'd1, 8'hA5);
      tick(); idle();
      repeat (3) tick();

      @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
